// File: rtl/button_debouncer_pkg.sv
// Shared board constants for a 100 MHz system clock.
// Consumed by board-level input conditioning blocks such as button_debouncer.
package button_debouncer_pkg;

    localparam int CLOCK_HZ = 100_000_000;

    // 10 ms debounce window and 1 s long-press threshold at CLOCK_HZ
    localparam int DEBOUNCE_CYCLES_DEFAULT   = CLOCK_HZ / 100;
    localparam int LONG_PRESS_CYCLES_DEFAULT = CLOCK_HZ;

    function automatic int ms_to_cycles(input int ms);
        return (CLOCK_HZ / 1000) * ms;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level input.
// Resets to 0 so a held input is not seen until two clock edges after reset release.
module sync_2ff (
    input  logic clock,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_p0;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            meta_p0 <= 1'b0;
            q       <= 1'b0;
        end else begin
            meta_p0 <= d;
            q       <= meta_p0;
        end
    end

endmodule

// File: rtl/button_debouncer.sv
// Push-button debouncer: synchronizes button_raw, accepts a level change only after
// DEBOUNCE_CYCLES stable samples, and flags long presses and aborted debounce waits.
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = DEBOUNCE_CYCLES_DEFAULT,
    parameter int LONG_PRESS_CYCLES = LONG_PRESS_CYCLES_DEFAULT
) (
    input  logic clock,
    input  logic rst_n,
    input  logic button_raw,
    output logic signal_debounced,
    output logic long_press,
    output logic bounce_seen
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    state_t            state;
    logic [DB_W-1:0]   db_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              sync;

    sync_2ff u_sync (
        .clock (clock),
        .rst_n (rst_n),
        .d     (button_raw),
        .q     (sync)
    );

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            db_cnt           <= '0;
            hold_cnt         <= '0;
            signal_debounced <= 1'b0;
            long_press       <= 1'b0;
            bounce_seen      <= 1'b0;
        end else begin
            bounce_seen <= 1'b0;
            unique case (state)
                IDLE: begin
                    db_cnt           <= '0;
                    hold_cnt         <= '0;
                    signal_debounced <= 1'b0;
                    long_press       <= 1'b0;
                    if (sync) begin
                        state <= PRESS_WAIT;
                    end
                end

                PRESS_WAIT: begin
                    if (!sync) begin
                        state       <= IDLE;
                        db_cnt      <= '0;
                        bounce_seen <= 1'b1;
                    end else if (db_cnt == DB_LAST) begin
                        state            <= PRESSED;
                        db_cnt           <= '0;
                        signal_debounced <= 1'b1;
                    end else begin
                        db_cnt <= db_cnt + DB_ONE;
                    end
                end

                PRESSED: begin
                    if (hold_cnt != HOLD_LAST) begin
                        hold_cnt <= hold_cnt + HOLD_ONE;
                    end else begin
                        long_press <= 1'b1;
                    end
                    if (!sync) begin
                        state  <= RELEASE_WAIT;
                        db_cnt <= '0;
                    end
                end

                RELEASE_WAIT: begin
                    // The hold count keeps running: the button is still debounced-pressed here
                    if (hold_cnt != HOLD_LAST) begin
                        hold_cnt <= hold_cnt + HOLD_ONE;
                    end else begin
                        long_press <= 1'b1;
                    end
                    if (sync) begin
                        state       <= PRESSED;
                        db_cnt      <= '0;
                        bounce_seen <= 1'b1;
                    end else if (db_cnt == DB_LAST) begin
                        state            <= IDLE;
                        db_cnt           <= '0;
                        hold_cnt         <= '0;
                        signal_debounced <= 1'b0;
                        long_press       <= 1'b0;
                    end else begin
                        db_cnt <= db_cnt + DB_ONE;
                    end
                end
            endcase
        end
    end

endmodule
